// File: rtl/pwm_pkg.sv
// Shared widths and reset constants for the PWM generator.
package pwm_pkg;
    localparam int PWM_WIDTH   = 8;
    localparam int PWM_PRESC_W = 8;

    localparam logic [PWM_WIDTH-1:0] TOP_RST  = '1;
    localparam logic [PWM_WIDTH-1:0] DUTY_RST = '0;
endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one tick every presc_i+1 enabled clocks.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESC_W = PWM_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               tick
);

    logic [PRESC_W-1:0] pc;

    // >= so a live decrease of presc_i below pc recovers on the next evaluation
    assign tick = ena && (pc >= presc_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (ena) begin
            if (pc >= presc_i) begin
                pc <= '0;
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_gen_core.sv
// Counter-based PWM core with double-buffered duty/period, applied only at wrap.
module pwm_gen_core
    import pwm_pkg::*;
#(
    parameter int WIDTH   = PWM_WIDTH,
    parameter int PRESC_W = PWM_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [WIDTH-1:0]   duty_i,
    input  logic               duty_wr,
    input  logic [WIDTH-1:0]   top_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               pwm_o,
    output logic               period_end_o,
    output logic [WIDTH-1:0]   cnt_o
);

    // Replicated so the all-ones reset period scales with WIDTH
    localparam logic [WIDTH-1:0] TOP_RST_W  = {WIDTH{&TOP_RST}};
    localparam logic [WIDTH-1:0] DUTY_RST_W = WIDTH'(DUTY_RST);

    logic             tick;
    logic             wrap;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] top_act;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] pend_duty;
    logic             pend_valid;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .presc_i (presc_i),
        .tick    (tick)
    );

    assign wrap  = tick && (cnt >= top_act);
    assign cnt_o = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            top_act      <= TOP_RST_W;
            duty_act     <= DUTY_RST_W;
            pend_duty    <= DUTY_RST_W;
            pend_valid   <= 1'b0;
            pwm_o        <= 1'b0;
            period_end_o <= 1'b0;
        end else begin
            if (tick) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end

            if (duty_wr) begin
                pend_duty <= duty_i;
            end

            // A write landing on the wrap cycle bypasses the shadow register
            if (wrap) begin
                top_act    <= top_i;
                duty_act   <= duty_wr ? duty_i : (pend_valid ? pend_duty : duty_act);
                pend_valid <= 1'b0;
            end else if (duty_wr) begin
                pend_valid <= 1'b1;
            end

            period_end_o <= wrap;
            pwm_o        <= ena && (cnt < duty_act);
        end
    end

endmodule
